ram_loader: RTL and testbench
=============================

Name: ram_loader

Overview:
- Upstream program loader for the 16-byte bus RAM.
- Receives a framed byte stream (sync byte, DEPTH data bytes, checksum) over a valid/ready byte interface.
- Requests the shared 8-bit bus from the control unit, then writes each data byte into RAM.
- Per byte: one cycle drives the address with address_load high; the next cycle drives the data with ram_load high.
- Releases the bus afterwards and reports done or err.

Parameters:
- DEPTH, 16: number of RAM bytes written per frame.
- AW, 4: address width; must satisfy DEPTH <= 2**AW.
- SYNC_BYTE, 8'hA5: frame start marker.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request to begin a load; ignored while busy.
- rx_valid  in  1  rx_data holds a byte.
- rx_data  in  8  incoming byte.
- rx_ready  out  1  loader accepts a byte this cycle.
- bus_grant  in  1  control unit has released the bus to the loader.
- bus_req  out  1  loader requests the bus.
- bus  inout  8  shared bus; driven only when permitted, otherwise 8'hzz.
- address_load  out  1  MAR load strobe.
- ram_load  out  1  RAM write strobe.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a frame or an abort.
- err  out  1  sticky error flag; cleared by the next accepted start.

Behaviour:
- Reset (clr=1): state IDLE, address counter 0, sum 0, data register 0. All outputs 0 (err included); bus=z.
- Byte handshake: a byte transfers on a rising edge where rx_valid && rx_ready. rx_ready is high only in SYNC, GET and CSUM, combinational from state.
- IDLE: on start -> REQ; clear err, address counter and sum.
- REQ: bus_req=1 (held from here through the cycle FINISH is entered). Wait for bus_grant -> SYNC.
- SYNC: accepted byte == SYNC_BYTE -> GET; any other byte is discarded and the state stays SYNC.
- GET: accepted byte is latched into the data register; sum += byte (mod 256) -> ADDR.
- ADDR: bus = {(8-AW)'b0, addr}; address_load=1 -> WRITE.
- WRITE: bus = data register; ram_load=1.
  - If addr == DEPTH-1 -> CSUM.
  - Else addr++ -> GET.
- CSUM: on an accepted byte, err = (byte != sum) -> FINISH.
- FINISH: bus_req=0; done=1 for one cycle -> IDLE.
- Bus driving: bus is driven only in ADDR/WRITE while bus_grant=1. In every other case bus=z. Strobes never assert without the loader driving the bus.
- Strobe separation: address_load and ram_load are never high together. The RAM write uses the MAR loaded on the previous edge.
- Grant loss: bus_grant=0 in SYNC, GET, ADDR, WRITE or CSUM aborts the frame. On the abort edge: err=1, next state FINISH, no further strobes.
- Throughput: minimum 3 cycles per data byte (GET, ADDR, WRITE) when rx_valid is continuously high.
- Minimum frame time: grant to done = 1 + 3*DEPTH + 1 + 1 cycles.
- Simultaneous events:
  - start while busy: ignored.
  - Grant loss takes priority over a byte accepted in the same cycle; that byte is dropped.
- clr mid-frame: immediate return to IDLE; bus released asynchronously. RAM contents already written are not rolled back.

Decomposition:
- Shared package holds:
  - State enum: IDLE, REQ, SYNC, GET, ADDR, WRITE, CSUM, FINISH.
  - Constant SYNC_BYTE default.
  - Bus-width constant (8).
- No sub-module. The tri-state bus driver is a single continuous assignment inside the block.

Test Plan:
- Normal load: grant held; frame A5, bytes 00..0F, checksum 78 -> 16 address_load/ram_load pairs; addresses 0..F on bus, then data 00..0F; done pulse; err=0; RAM holds 00..0F.
- Bad checksum: same frame with checksum 77 -> all 16 writes occur; done pulse; err=1; err clears on the next start.
- Noise before sync: bytes 3C, FF, then A5 and a valid frame -> first two bytes consumed without strobes; load completes correctly.
- Grant withheld: start with grant=0 for 10 cycles -> bus_req=1, rx_ready=0, bus=z throughout; load proceeds once grant rises.
- Grant lost after byte 5 is written -> no strobes after the abort edge; bus=z; done pulse; err=1; bus_req drops.
- Reset mid-frame: clr during WRITE of byte 8 -> all outputs 0 and bus=z immediately; a subsequent start runs a full frame correctly.

Source files
------------

// File: rtl/ram_loader_pkg.sv
// Shared types and constants for the RAM program loader.
// The state enum is shared so the top and any future tooling agree on names.
package ram_loader_pkg;

  localparam int BUS_W = 8;

  localparam logic [BUS_W-1:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    SYNC,
    GET,
    ADDR,
    WRITE,
    CSUM,
    FINISH
  } state_t;

endpackage

// File: rtl/ram_loader.sv
// Upstream program loader: takes a framed byte stream, borrows the shared bus
// and writes each data byte into RAM as an address_load / ram_load pair.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int               DEPTH     = 16,
  parameter int               AW        = 4,
  parameter logic [BUS_W-1:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             rx_valid,
  input  logic [BUS_W-1:0] rx_data,
  output logic             rx_ready,
  input  logic             bus_grant,
  output logic             bus_req,
  inout  wire  [BUS_W-1:0] bus,
  output logic             address_load,
  output logic             ram_load,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t           r_state;
  logic [AW-1:0]    r_addr;
  logic [BUS_W-1:0] r_sum;
  logic [BUS_W-1:0] r_data;
  logic             r_err;

  logic             w_accept;
  logic             w_in_frame;
  logic             w_abort;
  logic             w_drive;
  logic [BUS_W-1:0] w_bus_out;

  assign rx_ready   = (r_state == SYNC) || (r_state == GET) || (r_state == CSUM);
  assign w_accept   = rx_valid && rx_ready;
  assign w_in_frame = rx_ready || (r_state == ADDR) || (r_state == WRITE);
  assign w_abort    = w_in_frame && !bus_grant;

  // Drive and strobes are gated by the live grant, so a grant drop (or clr
  // forcing IDLE) releases the bus in the same cycle without waiting for an edge.
  assign w_drive   = bus_grant && ((r_state == ADDR) || (r_state == WRITE));
  assign w_bus_out = (r_state == ADDR) ? BUS_W'(r_addr) : r_data;
  assign bus       = w_drive ? w_bus_out : {BUS_W{1'bz}};

  assign address_load = w_drive && (r_state == ADDR);
  assign ram_load     = w_drive && (r_state == WRITE);
  assign busy         = (r_state != IDLE);
  assign done         = (r_state == FINISH);
  assign bus_req      = (r_state != IDLE) && (r_state != FINISH);
  assign err          = r_err;

  // NOTE: every register here uses <= so all state updates see pre-edge values.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_sum   <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else if (w_abort) begin
      // Grant loss wins over any byte offered in the same cycle.
      r_err   <= 1'b1;
      r_state <= FINISH;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_state <= REQ;
          r_err   <= 1'b0;
          r_addr  <= '0;
          r_sum   <= '0;
        end
        REQ:  if (bus_grant) r_state <= SYNC;
        SYNC: if (w_accept && (rx_data == SYNC_BYTE)) r_state <= GET;
        GET:  if (w_accept) begin
          r_data  <= rx_data;
          r_sum   <= r_sum + rx_data;
          r_state <= ADDR;
        end
        ADDR: r_state <= WRITE;
        WRITE: begin
          if (r_addr == AW'(DEPTH - 1)) begin
            r_state <= CSUM;
          end else begin
            r_addr  <= r_addr + 1'b1;
            r_state <= GET;
          end
        end
        CSUM: if (w_accept) begin
          r_err   <= (rx_data != r_sum);
          r_state <= FINISH;
        end
        FINISH:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader: fixed frame table, hand-built corner
// sequences and randomized frames against a stream-parsing reference model.
module tb_ram_loader;

  localparam int         DEPTH = 16;
  localparam logic [7:0] SYNC  = 8'hA5;
  localparam logic [7:0] FREE  = 8'hFF;   // pulled-up bus value when released

  typedef logic [7:0] byte_q_t[$];

  typedef struct {
    logic [7:0] base;       // data byte i = base + i
    int         n_noise;    // leading noise bytes (3C, FF)
    logic [7:0] csum;
    bit         exp_err;
    int         exp_cyc;    // REQ-with-grant cycle to done cycle
  } vec_t;

  logic       clk = 1'b0;
  logic       clr, start, rx_valid, bus_grant;
  logic [7:0] rx_data;
  logic       rx_ready, bus_req, address_load, ram_load, busy, done, err;
  wire  [7:0] bus;

  ram_loader #(.DEPTH(DEPTH), .AW(4), .SYNC_BYTE(SYNC)) dut (
    .clk(clk), .clr(clr), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .bus_grant(bus_grant), .bus_req(bus_req), .bus(bus),
    .address_load(address_load), .ram_load(ram_load), .busy(busy), .done(done),
    .err(err)
  );

  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup u_pu (bus[g]);
  end

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Bus-side observer: behaves like the MAR + RAM and counts protocol slips.
  int         cyc = 0;
  int         wr_cnt, al_cnt, done_cnt, viol;
  logic [7:0] ram [DEPTH];
  logic [3:0] mar;
  int         addr_log[$];

  always @(posedge clk) begin
    cyc++;
    if (address_load && ram_load) viol++;
    if (!bus_grant && bus !== FREE) viol++;
    if (address_load) begin
      mar = bus[3:0];
      al_cnt++;
      addr_log.push_back(int'(bus));
    end
    if (ram_load) begin
      ram[mar] = bus;
      wr_cnt++;
    end
    if (done) done_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_mon();
    wr_cnt = 0; al_cnt = 0; done_cnt = 0; viol = 0;
    addr_log.delete();
    for (int i = 0; i < DEPTH; i++) ram[i] = 8'hxx;
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the REQ cycle.
  task automatic start_load();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("err_cleared_on_start", err, 0);
  endtask

  // Offers stream bytes until all transferred, or stops early on an abort/clr trigger.
  task automatic feed(input byte_q_t q, input bit gaps, input int abort_at, input int clr_at);
    int idx = 0;
    bit xfer;
    for (int n = 0; n < 3000 && idx < q.size(); n++) begin
      if (abort_at >= 0 && wr_cnt == abort_at) begin
        start = 1'b0; bus_grant = 1'b0;
        return;
      end
      if (clr_at >= 0 && ram_load && wr_cnt == clr_at) begin
        start = 1'b0; clr = 1'b1;
        return;
      end
      rx_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      rx_data  = q[idx];
      start    = gaps ? ($urandom_range(0, 7) == 0) : 1'b0;
      xfer     = rx_valid && rx_ready;
      @(posedge clk);
      if (xfer) idx++;
      @(negedge clk);
    end
    rx_valid = 1'b0;
    start    = 1'b0;
    check("feed_complete", idx, q.size());
  endtask

  task automatic wait_done(output int t);
    int n = 0;
    while (done !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    t = cyc;
    check("done_seen", done, 1);
  endtask

  // Called at the done negedge.
  task automatic verify_frame(input byte_q_t exp, input bit exp_err);
    int bad = 0;
    check("err_at_done", err, exp_err);
    check("bus_req_low_at_done", bus_req, 0);
    @(negedge clk);
    check("done_pulses", done_cnt, 1);
    check("ram_load_count", wr_cnt, DEPTH);
    check("address_load_count", al_cnt, DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      if (ram[i] !== exp[i]) bad++;
      if (i >= addr_log.size() || addr_log[i] != i) bad++;
    end
    check("ram_and_addr_order", bad, 0);
    check("protocol_violations", viol, 0);
    check("idle_after_frame", {busy, bus_req, done, rx_ready}, 0);
    check("bus_released_idle", bus, FREE);
  endtask

  // Reference: skip to the first sync byte, take DEPTH data bytes, compare checksum.
  function automatic void model(input byte_q_t s, output byte_q_t data, output bit e);
    int         k = 0;
    logic [7:0] sum = 8'h00;
    data = {};
    while (k < s.size() && s[k] != SYNC) k++;
    k++;
    for (int i = 0; i < DEPTH; i++) begin
      data.push_back(s[k + i]);
      sum = sum + s[k + i];
    end
    e = (s[k + DEPTH] != sum);
  endfunction

  function automatic byte_q_t ramp_frame();
    byte_q_t q = {};
    q.push_back(SYNC);
    for (int i = 0; i < DEPTH; i++) q.push_back(8'(i));
    q.push_back(8'h78);
    return q;
  endfunction

  function automatic byte_q_t ramp_data();
    byte_q_t q = {};
    for (int i = 0; i < DEPTH; i++) q.push_back(8'(i));
    return q;
  endfunction

  initial begin
    vec_t       tbl[4];
    byte_q_t    q, exp;
    logic [7:0] noise[2];
    logic [7:0] b, sum;
    bit         e;
    int         t0, t1, bad, n;

    tbl[0] = '{8'h00, 0, 8'h78, 1'b0, 51};
    tbl[1] = '{8'h00, 0, 8'h77, 1'b1, 51};
    tbl[2] = '{8'h00, 2, 8'h78, 1'b0, 53};
    tbl[3] = '{8'hF8, 0, 8'hF8, 1'b0, 51};
    noise[0] = 8'h3C;
    noise[1] = 8'hFF;

    clr = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; bus_grant = 1'b1;
    #1;
    check("reset_outputs", {rx_ready, bus_req, address_load, ram_load, busy, done, err}, 0);
    check("reset_bus_released", bus, FREE);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);

    // Table-driven frames with rx_valid held high.
    for (int v = 0; v < 4; v++) begin
      q = {};
      exp = {};
      for (int i = 0; i < tbl[v].n_noise; i++) q.push_back(noise[i]);
      q.push_back(SYNC);
      for (int i = 0; i < DEPTH; i++) begin
        q.push_back(tbl[v].base + 8'(i));
        exp.push_back(tbl[v].base + 8'(i));
      end
      q.push_back(tbl[v].csum);
      clear_mon();
      start_load();
      t0 = cyc;
      feed(q, 1'b0, -1, -1);
      wait_done(t1);
      check("frame_cycles", t1 - t0, tbl[v].exp_cyc);
      verify_frame(exp, tbl[v].exp_err);
    end

    // Grant withheld for 10 cycles, then a normal load.
    bus_grant = 1'b0;
    clear_mon();
    start_load();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus_req !== 1'b1 || rx_ready !== 1'b0 || bus !== FREE) bad++;
      @(negedge clk);
    end
    check("withheld_grant_hold", bad, 0);
    bus_grant = 1'b1;
    t0 = cyc;
    feed(ramp_frame(), 1'b0, -1, -1);
    wait_done(t1);
    check("withheld_frame_cycles", t1 - t0, 51);
    verify_frame(ramp_data(), 1'b0);

    // Grant lost once five bytes are written; a byte is offered on the abort edge.
    clear_mon();
    start_load();
    feed(ramp_frame(), 1'b0, 5, -1);
    check("abort_bus_released", bus, FREE);
    check("abort_no_strobe_now", {address_load, ram_load}, 0);
    wait_done(t1);
    check("abort_err", err, 1);
    check("abort_bus_req_dropped", bus_req, 0);
    rx_valid = 1'b0;
    @(negedge clk);
    check("abort_writes", wr_cnt, 5);
    check("abort_addr_loads", al_cnt, 5);
    check("abort_done_pulses", done_cnt, 1);
    check("abort_idle", {busy, bus_req}, 0);
    bus_grant = 1'b1;

    // clr during the WRITE of byte 8, then a clean frame.
    clear_mon();
    start_load();
    feed(ramp_frame(), 1'b0, -1, 8);
    #1;
    check("clr_outputs", {rx_ready, bus_req, address_load, ram_load, busy, done, err}, 0);
    check("clr_bus_released", bus, FREE);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
    rx_valid = 1'b0;
    check("clr_writes_kept", wr_cnt, 8);
    @(negedge clk);
    clear_mon();
    start_load();
    t0 = cyc;
    feed(ramp_frame(), 1'b0, -1, -1);
    wait_done(t1);
    check("post_clr_frame_cycles", t1 - t0, 51);
    verify_frame(ramp_data(), 1'b0);

    // Randomized frames: noise, valid gaps, stray start pulses, random checksum errors.
    for (int r = 0; r < 20; r++) begin
      q = {};
      n = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        if (b == SYNC) b = 8'h5A;
        q.push_back(b);
      end
      q.push_back(SYNC);
      sum = 8'h00;
      for (int i = 0; i < DEPTH; i++) begin
        b = 8'($urandom);
        q.push_back(b);
        sum = sum + b;
      end
      if ($urandom_range(0, 1) == 1) q.push_back(sum);
      else q.push_back(sum ^ 8'($urandom_range(1, 255)));
      model(q, exp, e);
      clear_mon();
      start_load();
      feed(q, 1'b1, -1, -1);
      wait_done(t1);
      verify_frame(exp, e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
